// File: rtl/tdm_pkg.sv
// Shared types and constants for the four-slot TDM receive path.
// Used by tdm_slot_ctr and tdm_demux.
package tdm_pkg;
  localparam int TDM_SLOTS = 4;
  typedef logic [1:0] slot_t;
  localparam slot_t SLOT_LAST = 2'd3;
endpackage

// File: rtl/tdm_slot_ctr.sv
// Rotating 2-bit slot counter for the TDM demux.
// sync forces slot 1 because the syncing beat itself fills slot 0.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  adv,
  input  logic  sync,
  output slot_t slot,
  output logic  wrap
);

  slot_t slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (sync) begin
      slot_d = slot_t'(1);
    end else if (adv) begin
      slot_d = slot_q + slot_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;
  assign wrap = adv && !sync && (slot_q == SLOT_LAST);

endmodule

// File: rtl/tdm_demux.sv
// Four-slot TDM demultiplexer: collects W-bit beats and publishes frames.
// Optional resync error reporting with TDM_DEMUX_ERR_EN.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int W = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W-1:0]       din,
  input  logic               din_valid,
  input  logic               sof,
  output logic [TDM_SLOTS*W-1:0] dout,
  output logic               frame_valid,
`ifdef TDM_DEMUX_ERR_EN
  output logic               frame_err,
  output logic [7:0]         err_count,
`endif
  output slot_t              slot
);

  slot_t beat_slot;
  logic  sync;
  logic  wrap;

  logic [2:0][W-1:0]         shadow_q, shadow_d;
  logic [TDM_SLOTS*W-1:0]    dout_q, dout_d;
  logic                      fv_q, fv_d;

  assign sync      = din_valid && sof;
  assign beat_slot = sof ? slot_t'(0) : slot;

  tdm_slot_ctr u_ctr (
    .clk  (clk),
    .rst  (rst),
    .adv  (din_valid),
    .sync (sync),
    .slot (slot),
    .wrap (wrap)
  );

  always_comb begin
    shadow_d = shadow_q;
    for (int k = 0; k < 3; k++) begin
      if (din_valid && beat_slot == slot_t'(k)) begin
        shadow_d[k] = din;
      end
    end
  end

  // Publish only on a genuine slot-3 beat; dout never shows partial data.
  always_comb begin
    dout_d = dout_q;
    fv_d   = wrap;
    if (wrap) begin
      dout_d = {din, shadow_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      dout_q   <= '0;
      fv_q     <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      fv_q     <= fv_d;
    end
  end

  assign dout        = dout_q;
  assign frame_valid = fv_q;

`ifdef TDM_DEMUX_ERR_EN
  logic       resync;
  logic       err_q, err_d;
  logic [7:0] cnt_q, cnt_d;

  assign resync = sync && (slot != slot_t'(0));

  always_comb begin
    err_d = resync;
    cnt_d = cnt_q;
    if (resync && cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign frame_err = err_q;
  assign err_count = cnt_q;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Testbench for tdm_demux (W=4): vector table, directed corners, random vs model.
// Error-port checks are enabled with TDM_DEMUX_ERR_EN.
module tb_tdm_demux;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  din = '0;
  logic        din_valid = 1'b0;
  logic        sof = 1'b0;
  logic [15:0] dout;
  logic        frame_valid;
  logic [1:0]  slot;
`ifdef TDM_DEMUX_ERR_EN
  logic        frame_err;
  logic [7:0]  err_count;
`endif

  tdm_demux #(.W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .sof         (sof),
    .dout        (dout),
    .frame_valid (frame_valid),
`ifdef TDM_DEMUX_ERR_EN
    .frame_err   (frame_err),
    .err_count   (err_count),
`endif
    .slot        (slot)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: collected samples of the frame in progress.
  logic [3:0]  mq[$];
  logic [15:0] m_dout = '0;
  bit          m_fv = 0;
  bit          m_ferr = 0;
  int          m_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit s, input bit v,
                              input logic [3:0] d);
    if (r) begin
      mq.delete();
      m_dout = '0;
      m_fv = 0;
      m_ferr = 0;
      m_err = 0;
    end else begin
      m_fv = 0;
      m_ferr = 0;
      if (v) begin
        if (s) begin
          if (mq.size() != 0) begin
            m_ferr = 1;
            if (m_err < 255) m_err++;
          end
          mq.delete();
        end
        mq.push_back(d);
        if (mq.size() == 4) begin
          m_dout = {mq[3], mq[2], mq[1], mq[0]};
          m_fv = 1;
          mq.delete();
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit s, input bit v,
                      input logic [3:0] d);
    rst = r;
    sof = s;
    din_valid = v;
    din = d;
    @(posedge clk);
    model_update(r, s, v, d);
    #1;
    rst = 1'b0;
    sof = 1'b0;
    din_valid = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".dout"}, int'(dout), int'(m_dout));
    chk({tag, ".fv"}, int'(frame_valid), int'(m_fv));
    chk({tag, ".slot"}, int'(slot), mq.size());
`ifdef TDM_DEMUX_ERR_EN
    chk({tag, ".ferr"}, int'(frame_err), int'(m_ferr));
    chk({tag, ".ecnt"}, int'(err_count), m_err);
`endif
  endtask

  typedef struct {
    bit          s;
    bit          v;
    logic [3:0]  d;
    logic [15:0] dout;
    bit          fv;
    logic [1:0]  slot;
  } vec_t;

  vec_t vecs[12];
  int   pulses;
  int   pulse_t;

  initial begin
    // Single frame, then back-to-back frames 0x1..0x8.
    vecs[0]  = '{1, 1, 4'hA, 16'h0000, 0, 2'd1};
    vecs[1]  = '{0, 1, 4'hB, 16'h0000, 0, 2'd2};
    vecs[2]  = '{0, 1, 4'hC, 16'h0000, 0, 2'd3};
    vecs[3]  = '{0, 1, 4'hD, 16'hDCBA, 1, 2'd0};
    vecs[4]  = '{1, 1, 4'h1, 16'hDCBA, 0, 2'd1};
    vecs[5]  = '{0, 1, 4'h2, 16'hDCBA, 0, 2'd2};
    vecs[6]  = '{0, 1, 4'h3, 16'hDCBA, 0, 2'd3};
    vecs[7]  = '{0, 1, 4'h4, 16'h4321, 1, 2'd0};
    vecs[8]  = '{1, 1, 4'h5, 16'h4321, 0, 2'd1};
    vecs[9]  = '{0, 1, 4'h6, 16'h4321, 0, 2'd2};
    vecs[10] = '{0, 1, 4'h7, 16'h4321, 0, 2'd3};
    vecs[11] = '{0, 1, 4'h8, 16'h8765, 1, 2'd0};

    step(1, 0, 0, 4'h0);
    chk("reset.dout", int'(dout), 0);
    chk("reset.fv", int'(frame_valid), 0);
    chk("reset.slot", int'(slot), 0);
`ifdef TDM_DEMUX_ERR_EN
    chk("reset.ecnt", int'(err_count), 0);
    chk("reset.ferr", int'(frame_err), 0);
`endif

    for (int i = 0; i < 12; i++) begin
      step(0, vecs[i].s, vecs[i].v, vecs[i].d);
      chk($sformatf("vec%0d.dout", i), int'(dout), int'(vecs[i].dout));
      chk($sformatf("vec%0d.fv", i), int'(frame_valid), int'(vecs[i].fv));
      chk($sformatf("vec%0d.slot", i), int'(slot), int'(vecs[i].slot));
    end
    step(0, 0, 0, 4'h0);
    chk("single.fv_drop", int'(frame_valid), 0);
    chk("idle.dout_hold", int'(dout), 16'h8765);

    // Gapped beats: 3 idle cycles between beats.
    step(1, 0, 0, 4'h0);
    pulses = 0;
    pulse_t = -1;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] gd;
      gd = 4'hA + 4'(i);
      step(0, i == 0, 1, gd);
      if (frame_valid) begin pulses++; pulse_t = i * 4; end
      for (int g = 0; g < 3; g++) begin
        step(0, 1, 0, 4'hF);
        if (frame_valid) begin pulses++; pulse_t = i * 4 + g + 1; end
      end
    end
    chk("gap.pulses", pulses, 1);
    chk("gap.pulse_time", pulse_t, 12);
    chk("gap.dout", int'(dout), 16'hDCBA);
    chk("gap.slot", int'(slot), 0);

    // Resync: 1,2 then sof 9, A,B,C.
    step(1, 0, 0, 4'h0);
    pulses = 0;
    step(0, 1, 1, 4'h1); pulses += int'(frame_valid);
    step(0, 0, 1, 4'h2); pulses += int'(frame_valid);
    step(0, 1, 1, 4'h9); pulses += int'(frame_valid);
    chk("resync.slot", int'(slot), 1);
`ifdef TDM_DEMUX_ERR_EN
    chk("resync.ferr", int'(frame_err), 1);
`endif
    step(0, 0, 1, 4'hA); pulses += int'(frame_valid);
`ifdef TDM_DEMUX_ERR_EN
    chk("resync.ferr_drop", int'(frame_err), 0);
`endif
    step(0, 0, 1, 4'hB); pulses += int'(frame_valid);
    chk("resync.no_partial", pulses, 0);
    step(0, 0, 1, 4'hC);
    chk("resync.fv", int'(frame_valid), 1);
    chk("resync.dout", int'(dout), 16'hCBA9);
`ifdef TDM_DEMUX_ERR_EN
    chk("resync.ecnt", int'(err_count), 1);
`endif

    // Reset mid-frame, with a beat offered in the reset cycle.
    step(0, 1, 1, 4'h1);
    step(0, 0, 1, 4'h2);
    step(0, 0, 1, 4'h3);
    step(1, 0, 1, 4'h4);
    chk("rstmid.dout", int'(dout), 0);
    chk("rstmid.slot", int'(slot), 0);
    pulses = 0;
    step(0, 1, 1, 4'h5); pulses += int'(frame_valid);
    step(0, 0, 1, 4'h6); pulses += int'(frame_valid);
    step(0, 0, 1, 4'h7); pulses += int'(frame_valid);
    chk("rstmid.no_early", pulses, 0);
    step(0, 0, 1, 4'h8);
    chk("rstmid.fv", int'(frame_valid), 1);
    chk("rstmid.dout2", int'(dout), 16'h8765);

`ifdef TDM_DEMUX_ERR_EN
    // Saturation: first sof lands on slot 0, the next 300 all resync.
    step(1, 0, 0, 4'h0);
    for (int i = 0; i < 301; i++) step(0, 1, 1, 4'(i));
    chk("sat.ecnt", int'(err_count), 255);
    chk("sat.model", int'(err_count), m_err);
`endif

    // Random traffic against the model.
    step(1, 0, 0, 4'h0);
    check_model("rnd0");
    for (int i = 0; i < 600; i++) begin
      bit r, s, v;
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 7) == 0);
      step(r, s, v, 4'($urandom));
      check_model("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Four-slot time-division demultiplexer, the receive-side counterpart of the 4:1 `mux`. It accepts one W-bit sample per valid beat and steers successive samples into lanes 0..3 using an internal rotating slot counter. When the slot-3 sample arrives, it publishes the completed 4-lane frame atomically. It sits downstream of a select-driven mux or TDM link and rebuilds the parallel word.

## Interface
- `W`, default 1: width of one slot sample in bits.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `din`  input  W  slot sample.
- `din_valid`  input  1  `din` is valid this cycle.
- `sof`  input  1  start-of-frame marker. Sampled only when `din_valid` is 1. Marks the beat as slot 0.
- `dout`  output  4*W  last complete frame. Lane k occupies bits `[k*W +: W]`.
- `frame_valid`  output  1  one-cycle pulse when `dout` is updated.
- `slot`  output  2  slot index the next valid beat will occupy.
- `frame_err`  output  1  present only with `TDM_DEMUX_ERR_EN`; see Configuration.
- `err_count`  output  8  present only with `TDM_DEMUX_ERR_EN`; see Configuration.

## Operation
- **Reset values:** `slot`=0, shadow lanes 0..2 = 0, `dout`=0, `frame_valid`=0, `frame_err`=0, `err_count`=0.
- **Beat:** a cycle with `din_valid`=1. Slot used by the beat:
  - 0 if `sof`=1;
  - otherwise the current `slot`.
- **Slots 0..2:** `din` is written to shadow lane `s`; `slot` becomes `s+1`.
- **Slot 3:**
  - `dout` is loaded with `{din, shadow2, shadow1, shadow0}`;
  - `frame_valid`=1 for the next cycle only;
  - `slot` wraps to 0.
- **Idle:** `din_valid`=0 leaves `slot`, the shadows and `dout` unchanged, and `frame_valid`=0. Gaps between beats are unlimited.
- **`sof` while `slot`≠0 (resync):**
  - the partial frame is discarded and `dout` is not updated;
  - the beat is written to shadow lane 0 and `slot` becomes 1;
  - shadows 1..2 keep stale data, which is overwritten before the next publish.
- **`sof` while `slot`=0:** normal slot-0 beat; no error.
- **`sof` while `din_valid`=0:** ignored.
- **`dout` hold:** `dout` holds its value between frames and never shows a partial frame.
- **`rst` during a frame:** all state returns to reset values in the next cycle. A beat presented in the same cycle as `rst` is dropped.

## Timing
- **Latency:** the slot-3 beat is sampled at edge N. `dout` and `frame_valid` are valid after edge N (visible in cycle N+1).
- **Throughput:** one beat per cycle. Back-to-back frames give `frame_valid` exactly every 4th cycle.
- **`slot` output:** registered. After edge N it reflects beats up to and including edge N.
- **Combinational paths:** none from inputs to outputs. All outputs are registered.
- **Arithmetic:** `slot` is 2 bits and wraps 3→0 naturally. `err_count` saturates at 255 and does not wrap.

## Configuration
- **Macro:** `TDM_DEMUX_ERR_EN`.
- **Defined:**
  - `frame_err` pulses for one cycle after any resync beat (`sof`=1, `din_valid`=1, `slot`≠0);
  - `err_count` increments on each resync and saturates at 255;
  - `frame_err` and `err_count` are cleared by `rst`.
- **Undefined:**
  - both ports and their logic are absent;
  - resync behaviour is otherwise identical.

## Structure
- **Package `tdm_pkg`:**
  - `localparam TDM_SLOTS = 4`;
  - `typedef logic [1:0] slot_t`;
  - `localparam slot_t SLOT_LAST = 2'd3`.
- **Sub-module `tdm_slot_ctr`:**
  - 2-bit slot counter with inputs `clk`, `rst`, `adv`, `sync`;
  - outputs `slot` and `wrap`;
  - `sync` forces the next value to 1.
- **Top level:** the shadow lanes, `dout` register, pulse generation and error logic live in `tdm_demux` itself.

## Test plan
All scenarios use `W`=4.
1. **Single frame:** after reset, beats 0xA,0xB,0xC,0xD with `sof` on 0xA → `dout`=0xDCBA, `frame_valid` high for exactly 1 cycle, `slot`=0.
2. **Gapped beats:** same data with `din_valid` low for 3 cycles between each beat → identical `dout`. `frame_valid` pulses once, 1 cycle after 0xD is sampled.
3. **Back-to-back frames:** 8 consecutive beats 0x1..0x8, `sof` on 0x1 and 0x5 → `dout`=0x4321 then 0x8765, pulses 4 cycles apart.
4. **Resync:** beats 0x1,0x2 then `sof` with 0x9, then 0xA,0xB,0xC →
   - no pulse for the partial frame;
   - `dout`=0xCBA9;
   - with `TDM_DEMUX_ERR_EN`, `frame_err` pulses once and `err_count`=1.
5. **Reset mid-frame:** beats 0x1,0x2,0x3, then `rst` for 1 cycle, then a full frame 0x5..0x8 → `dout`=0 after reset, then 0x8765. No pulse before 0x8.
6. **Saturation** (`TDM_DEMUX_ERR_EN` only): 300 resync beats → `err_count` stops at 255.
